// File: rtl/ahb_bram_arb2.sv
// Two-master AHB-Lite arbiter in front of one shared BRAM slave port.
// Losing masters are parked in a one-entry pending register and stalled via HREADYOUT.
module ahb_bram_arb2 #(
  parameter int ADDRESSWIDTH = 14
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,

  input  logic                    M0_HSEL,
  input  logic                    M0_HREADY,
  input  logic [1:0]              M0_HTRANS,
  input  logic [1:0]              M0_HSIZE,
  input  logic                    M0_HWRITE,
  input  logic [ADDRESSWIDTH-1:0] M0_HADDR,
  input  logic [31:0]             M0_HWDATA,
  output logic                    M0_HREADYOUT,
  output logic                    M0_HRESP,
  output logic [31:0]             M0_HRDATA,

  input  logic                    M1_HSEL,
  input  logic                    M1_HREADY,
  input  logic [1:0]              M1_HTRANS,
  input  logic [1:0]              M1_HSIZE,
  input  logic                    M1_HWRITE,
  input  logic [ADDRESSWIDTH-1:0] M1_HADDR,
  input  logic [31:0]             M1_HWDATA,
  output logic                    M1_HREADYOUT,
  output logic                    M1_HRESP,
  output logic [31:0]             M1_HRDATA,

  output logic                    S_HSEL,
  output logic [1:0]              S_HTRANS,
  output logic [1:0]              S_HSIZE,
  output logic                    S_HWRITE,
  output logic [ADDRESSWIDTH-1:0] S_HADDR,
  output logic [31:0]             S_HWDATA,
  output logic                    S_HREADY,
  input  logic                    S_HREADYOUT,
  input  logic                    S_HRESP,
  input  logic [31:0]             S_HRDATA
);

  localparam int AW = ADDRESSWIDTH - 1;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

  owner_e      owner_q, owner_d;
  logic        last_q, last_d;  // 1 when M1 received the most recent grant
  logic [1:0]  pend_vld_q, pend_vld_d;
  logic [1:0]  pend_wr_q, pend_wr_d;
  logic [1:0]  pend_size_q [2];
  logic [1:0]  pend_size_d [2];
  logic [AW:0] pend_addr_q [2];
  logic [AW:0] pend_addr_d [2];
  logic [AW:0] s_addr_q, s_addr_d;
  logic [1:0]  s_size_q, s_size_d;
  logic        s_wr_q, s_wr_d;

  logic [1:0]  m_sel, m_rdy, m_wr;
  logic [1:0]  m_trans [2];
  logic [1:0]  m_size [2];
  logic [AW:0] m_addr [2];
  logic [1:0]  live, cand, cand_wr, issue, owner_is, hrdyout, hresp;
  logic [1:0]  cand_size [2];
  logic [AW:0] cand_addr [2];
  logic        slot_free, issue_any, gnt;

  assign m_sel      = {M1_HSEL, M0_HSEL};
  assign m_rdy      = {M1_HREADY, M0_HREADY};
  assign m_wr       = {M1_HWRITE, M0_HWRITE};
  assign m_trans[0] = M0_HTRANS;
  assign m_trans[1] = M1_HTRANS;
  assign m_size[0]  = M0_HSIZE;
  assign m_size[1]  = M1_HSIZE;
  assign m_addr[0]  = M0_HADDR;
  assign m_addr[1]  = M1_HADDR;
  assign owner_is   = {owner_q == OWN_M1, owner_q == OWN_M0};

  // A parked master is stalled, so its bus cannot present a fresh request.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_m
      assign live[gi]      = m_sel[gi] & m_rdy[gi] & ~pend_vld_q[gi]
                             & ((m_trans[gi] == 2'b10) | (m_trans[gi] == 2'b11));
      assign cand[gi]      = pend_vld_q[gi] | live[gi];
      assign cand_addr[gi] = pend_vld_q[gi] ? pend_addr_q[gi] : m_addr[gi];
      assign cand_size[gi] = pend_vld_q[gi] ? pend_size_q[gi] : m_size[gi];
      assign cand_wr[gi]   = pend_vld_q[gi] ? pend_wr_q[gi]   : m_wr[gi];
      assign hrdyout[gi]   = owner_is[gi] ? S_HREADYOUT : ~pend_vld_q[gi];
      assign hresp[gi]     = owner_is[gi] ? S_HRESP : 1'b0;
    end
  endgenerate

  always_comb begin
    slot_free = (owner_q == OWN_NONE) | S_HREADYOUT;
    issue     = 2'b00;
    if (slot_free) begin
      if (&cand) issue = last_q ? 2'b01 : 2'b10;
      else       issue = cand;
    end
    issue_any = |issue;
    gnt       = issue[1];
    last_d    = issue_any ? gnt : last_q;

    owner_d = owner_q;
    if (slot_free) owner_d = issue[0] ? OWN_M0 : (issue[1] ? OWN_M1 : OWN_NONE);

    // Idle cycles keep the last address-phase controls on the slave port.
    s_addr_d = issue_any ? cand_addr[gnt] : s_addr_q;
    s_size_d = issue_any ? cand_size[gnt] : s_size_q;
    s_wr_d   = issue_any ? cand_wr[gnt]   : s_wr_q;

    pend_vld_d = pend_vld_q;
    pend_wr_d  = pend_wr_q;
    for (int i = 0; i < 2; i++) begin
      pend_addr_d[i] = pend_addr_q[i];
      pend_size_d[i] = pend_size_q[i];
      if (issue[i]) begin
        pend_vld_d[i] = 1'b0;
      end else if (live[i]) begin
        pend_vld_d[i]  = 1'b1;
        pend_addr_d[i] = m_addr[i];
        pend_size_d[i] = m_size[i];
        pend_wr_d[i]   = m_wr[i];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q    <= OWN_NONE;
      last_q     <= 1'b1;
      pend_vld_q <= 2'b00;
      pend_wr_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        pend_addr_q[i] <= '0;
        pend_size_q[i] <= 2'b00;
      end
      s_addr_q <= '0;
      s_size_q <= 2'b00;
      s_wr_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      pend_vld_q <= pend_vld_d;
      pend_wr_q  <= pend_wr_d;
      for (int i = 0; i < 2; i++) begin
        pend_addr_q[i] <= pend_addr_d[i];
        pend_size_q[i] <= pend_size_d[i];
      end
      s_addr_q <= s_addr_d;
      s_size_q <= s_size_d;
      s_wr_q   <= s_wr_d;
    end
  end

  always_comb begin
    S_HWDATA = 32'h0;
    case (owner_q)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = 32'h0;
    endcase
  end

  assign S_HSEL    = issue_any;
  assign S_HTRANS  = issue_any ? 2'b10 : 2'b00;
  assign S_HADDR   = s_addr_d;
  assign S_HSIZE   = s_size_d;
  assign S_HWRITE  = s_wr_d;
  assign S_HREADY  = (owner_q == OWN_NONE) ? 1'b1 : S_HREADYOUT;

  assign M0_HREADYOUT = hrdyout[0];
  assign M1_HREADYOUT = hrdyout[1];
  assign M0_HRESP     = hresp[0];
  assign M1_HRESP     = hresp[1];
  assign M0_HRDATA    = S_HRDATA;
  assign M1_HRDATA    = S_HRDATA;

endmodule

// File: tb/tb_ahb_bram_arb2.sv
// Directed bench for ahb_bram_arb2: behavioural BRAM slave, issue and per-master
// completion scoreboards checked by a negedge monitor.
module tb_ahb_bram_arb2;

  logic        HCLK, HRESETn;
  logic        M0_HSEL, M0_HREADY, M0_HWRITE, M0_HREADYOUT, M0_HRESP;
  logic [1:0]  M0_HTRANS, M0_HSIZE;
  logic [13:0] M0_HADDR;
  logic [31:0] M0_HWDATA, M0_HRDATA;
  logic        M1_HSEL, M1_HREADY, M1_HWRITE, M1_HREADYOUT, M1_HRESP;
  logic [1:0]  M1_HTRANS, M1_HSIZE;
  logic [13:0] M1_HADDR;
  logic [31:0] M1_HWDATA, M1_HRDATA;
  logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT, S_HRESP;
  logic [1:0]  S_HTRANS, S_HSIZE;
  logic [13:0] S_HADDR;
  logic [31:0] S_HWDATA, S_HRDATA;

  ahb_bram_arb2 #(.ADDRESSWIDTH(14)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(M0_HSEL), .M0_HREADY(M0_HREADY), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
    .M0_HWRITE(M0_HWRITE), .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA),
    .M0_HREADYOUT(M0_HREADYOUT), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
    .M1_HSEL(M1_HSEL), .M1_HREADY(M1_HREADY), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
    .M1_HWRITE(M1_HWRITE), .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA),
    .M1_HREADYOUT(M1_HREADYOUT), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HWRITE(S_HWRITE),
    .S_HADDR(S_HADDR), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
  );

  // Each master sits alone on its bus, so its HREADY is its own HREADYOUT.
  assign M0_HREADY = M0_HREADYOUT;
  assign M1_HREADY = M1_HREADYOUT;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Behavioural BRAM slave with a programmable wait count per data phase.
  logic [31:0] mem [16];
  logic        dp_act, dp_wr;
  logic [1:0]  dp_size;
  logic [13:0] dp_addr;
  int          wcnt;
  int          slave_wait;

  assign S_HREADYOUT = !(dp_act && wcnt != 0);
  assign S_HRDATA    = (dp_act && !dp_wr) ? mem[dp_addr[5:2]] : 32'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act  <= 1'b0;
      dp_wr   <= 1'b0;
      dp_size <= 2'b00;
      dp_addr <= '0;
      wcnt    <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (dp_act && wcnt != 0) begin
      wcnt <= wcnt - 1;
    end else begin
      if (dp_act && dp_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (dp_size == 2'd2 || (dp_size == 2'd1 && (b / 2) == int'(dp_addr[1]))
              || (dp_size == 2'd0 && b == int'(dp_addr[1:0])))
            mem[dp_addr[5:2]][8*b +: 8] <= S_HWDATA[8*b +: 8];
        end
      end
      if (S_HSEL && S_HREADY && S_HTRANS[1]) begin
        dp_act  <= 1'b1;
        dp_wr   <= S_HWRITE;
        dp_size <= S_HSIZE;
        dp_addr <= S_HADDR;
        wcnt    <= slave_wait;
      end else begin
        dp_act <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [13:0] addr;
    logic [1:0]  size;
    logic        wr;
  } iss_t;

  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
    logic        resp;
    logic [3:0]  waits;
  } mexp_t;

  iss_t  iq  [$];
  mexp_t mq0 [$];
  mexp_t mq1 [$];
  int    n_pass = 0;
  int    n_total = 0;
  logic  dp [2];
  int    wt [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
  endtask

  task automatic push_issue(input logic [13:0] a, input logic [1:0] s, input logic w);
    iss_t e;
    e.addr = a; e.size = s; e.wr = w;
    iq.push_back(e);
  endtask

  task automatic push_m(input int n, input logic rd, input logic [31:0] d, input logic r, input logic [3:0] w);
    mexp_t e;
    e.is_read = rd; e.rdata = d; e.resp = r; e.waits = w;
    if (n == 0) mq0.push_back(e);
    else        mq1.push_back(e);
  endtask

  task automatic mon_m(input int n, input logic rdy, input logic resp, input logic [31:0] rdata,
                       input logic sel, input logic [1:0] trans);
    mexp_t e;
    if (dp[n]) begin
      if (!rdy) begin
        wt[n]++;
      end else begin
        if ((n == 0 && mq0.size() == 0) || (n == 1 && mq1.size() == 0)) begin
          n_total++;
          $display("FAIL m%0d_unexpected_done: got completion expected none at %0t", n, $time);
        end else begin
          e = (n == 0) ? mq0.pop_front() : mq1.pop_front();
          chk($sformatf("m%0d_waits", n), 32'(wt[n]), 32'(e.waits));
          chk($sformatf("m%0d_hresp", n), 32'(resp), 32'(e.resp));
          if (e.is_read) chk($sformatf("m%0d_hrdata", n), rdata, e.rdata);
          $display("m%0d done read=%0d data=%08h resp=%0d waits=%0d", n, e.is_read, rdata, resp, wt[n]);
        end
        dp[n] = 1'b0;
      end
    end
    if (rdy && sel && trans[1]) begin
      dp[n] = 1'b1;
      wt[n] = 0;
    end
  endtask

  // Monitor: slave-side issues and master-side completions, sampled mid-cycle.
  initial begin
    iss_t ie;
    dp[0] = 1'b0; dp[1] = 1'b0; wt[0] = 0; wt[1] = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp[0] = 1'b0;
        dp[1] = 1'b0;
      end else begin
        if (S_HSEL) begin
          if (iq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_issue: got addr 0x%04h expected no issue at %0t", S_HADDR, $time);
          end else begin
            ie = iq.pop_front();
            chk("issue_addr", 32'(S_HADDR), 32'(ie.addr));
            chk("issue_ctl", 32'({S_HTRANS, S_HSIZE, S_HWRITE}), 32'({2'b10, ie.size, ie.wr}));
            $display("issue addr=%04h size=%0d write=%0d", S_HADDR, S_HSIZE, S_HWRITE);
          end
        end
        mon_m(0, M0_HREADYOUT, M0_HRESP, M0_HRDATA, M0_HSEL, M0_HTRANS);
        mon_m(1, M1_HREADYOUT, M1_HRESP, M1_HRDATA, M1_HSEL, M1_HTRANS);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic m_idle(input int n);
    if (n == 0) begin M0_HSEL = 1'b0; M0_HTRANS = 2'b00; end
    else        begin M1_HSEL = 1'b0; M1_HTRANS = 2'b00; end
  endtask

  task automatic m_req(input int n, input logic w, input logic [1:0] s, input logic [13:0] a);
    if (n == 0) begin
      M0_HSEL = 1'b1; M0_HTRANS = 2'b10; M0_HWRITE = w; M0_HSIZE = s; M0_HADDR = a;
    end else begin
      M1_HSEL = 1'b1; M1_HTRANS = 2'b10; M1_HWRITE = w; M1_HSIZE = s; M1_HADDR = a;
    end
  endtask

  task automatic do_reset;
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
  endtask

  initial begin
    logic [13:0] a0 [3];
    logic [13:0] a1 [3];
    int i0, i1;
    logic acc0, acc1;
    a0[0] = 14'h00; a0[1] = 14'h04; a0[2] = 14'h08;
    a1[0] = 14'h30; a1[1] = 14'h34; a1[2] = 14'h38;
    HRESETn = 1'b0; S_HRESP = 1'b0; slave_wait = 0;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    M0_HWRITE = 1'b0; M0_HSIZE = 2'd2; M0_HADDR = '0;
    M1_HWRITE = 1'b0; M1_HSIZE = 2'd2; M1_HADDR = '0;
    m_idle(0); m_idle(1);

    // Reset values
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_s_hsel", 32'(S_HSEL), 32'd0);
    chk("rst_s_htrans", 32'(S_HTRANS), 32'd0);
    chk("rst_m0_hreadyout", 32'(M0_HREADYOUT), 32'd1);
    chk("rst_m1_hreadyout", 32'(M1_HREADYOUT), 32'd1);
    chk("rst_m0_hresp", 32'(M0_HRESP), 32'd0);
    chk("rst_m1_hresp", 32'(M1_HRESP), 32'd0);
    #2 HRESETn = 1'b1;

    // Single-master write then read-back, no waits
    tick;
    m_req(0, 1'b1, 2'd2, 14'h0010);
    push_issue(14'h0010, 2'd2, 1'b1); push_m(0, 1'b0, 32'h0, 1'b0, 4'd0);
    @(negedge HCLK);
    chk("a_wr_hreadyout", 32'(M0_HREADYOUT), 32'd1);
    tick;
    M0_HWDATA = 32'h1122_3344;
    m_req(0, 1'b0, 2'd2, 14'h0010);
    push_issue(14'h0010, 2'd2, 1'b0); push_m(0, 1'b1, 32'h1122_3344, 1'b0, 4'd0);
    @(negedge HCLK);
    chk("a_s_hwdata", S_HWDATA, 32'h1122_3344);
    tick;
    m_idle(0); M0_HWDATA = 32'h0;
    @(negedge HCLK);
    chk("a_idle_htrans", 32'(S_HTRANS), 32'd0);
    chk("a_idle_haddr_held", 32'(S_HADDR), 32'h0010);
    tick;

    // Simultaneous back-to-back reads after reset: M0 first, then alternating
    do_reset;
    push_issue(14'h00, 2'd2, 1'b0); push_issue(14'h30, 2'd2, 1'b0);
    push_issue(14'h04, 2'd2, 1'b0); push_issue(14'h34, 2'd2, 1'b0);
    push_issue(14'h08, 2'd2, 1'b0); push_issue(14'h38, 2'd2, 1'b0);
    push_m(0, 1'b1, 32'hA000_0000, 1'b0, 4'd0);
    push_m(0, 1'b1, 32'hA000_0001, 1'b0, 4'd1);
    push_m(0, 1'b1, 32'hA000_0002, 1'b0, 4'd1);
    push_m(1, 1'b1, 32'hA000_000C, 1'b0, 4'd1);
    push_m(1, 1'b1, 32'hA000_000D, 1'b0, 4'd1);
    push_m(1, 1'b1, 32'hA000_000E, 1'b0, 4'd1);
    i0 = 0; i1 = 0;
    for (int c = 0; c < 7; c++) begin
      tick;
      if (i0 < 3) m_req(0, 1'b0, 2'd2, a0[i0]); else m_idle(0);
      if (i1 < 3) m_req(1, 1'b0, 2'd2, a1[i1]); else m_idle(1);
      @(negedge HCLK);
      if (c == 1) chk("b_m1_stall", 32'(M1_HREADYOUT), 32'd0);
      if (c == 2) chk("b_m1_ready", 32'(M1_HREADYOUT), 32'd1);
      acc0 = M0_HREADYOUT && M0_HSEL && M0_HTRANS[1];
      acc1 = M1_HREADYOUT && M1_HSEL && M1_HTRANS[1];
      if (acc0) i0++;
      if (acc1) i1++;
    end
    tick;
    m_idle(0); m_idle(1);
    tick;

    // M1 byte write parked behind a stalled M0 data phase
    slave_wait = 2;
    m_req(0, 1'b0, 2'd2, 14'h0008);
    push_issue(14'h0008, 2'd2, 1'b0); push_m(0, 1'b1, 32'hA000_0002, 1'b0, 4'd2);
    tick;
    slave_wait = 0;
    m_idle(0);
    m_req(1, 1'b1, 2'd0, 14'h0003);
    push_issue(14'h0003, 2'd0, 1'b1); push_m(1, 1'b0, 32'h0, 1'b0, 4'd2);
    @(negedge HCLK);
    chk("c_m1_accept", 32'(M1_HREADYOUT), 32'd1);
    tick;
    m_idle(1); M1_HWDATA = 32'hABAB_ABAB;
    @(negedge HCLK);
    chk("c_m1_pending", 32'(M1_HREADYOUT), 32'd0);
    chk("c_no_issue", 32'(S_HSEL), 32'd0);
    tick;
    tick;
    @(negedge HCLK);
    chk("c_s_hwdata", S_HWDATA, 32'hABAB_ABAB);
    tick;
    M1_HWDATA = 32'h0;
    m_req(0, 1'b0, 2'd2, 14'h0000);
    push_issue(14'h0000, 2'd2, 1'b0); push_m(0, 1'b1, 32'hAB00_0000, 1'b0, 4'd0);
    tick;
    m_idle(0);
    tick;

    // Error response during an M1 data phase
    m_req(1, 1'b0, 2'd2, 14'h0004);
    push_issue(14'h0004, 2'd2, 1'b0); push_m(1, 1'b1, 32'hA000_0001, 1'b1, 4'd0);
    tick;
    m_idle(1); S_HRESP = 1'b1;
    @(negedge HCLK);
    chk("d_m0_hresp", 32'(M0_HRESP), 32'd0);
    tick;
    S_HRESP = 1'b0;
    tick;

    // Reset pulse while M1 is parked discards it
    slave_wait = 2;
    m_req(0, 1'b0, 2'd2, 14'h0008);
    push_issue(14'h0008, 2'd2, 1'b0);
    tick;
    slave_wait = 0;
    m_idle(0);
    m_req(1, 1'b0, 2'd2, 14'h000C);
    tick;
    m_idle(1);
    @(negedge HCLK);
    chk("e_m1_pending", 32'(M1_HREADYOUT), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("e_rst_m1_hreadyout", 32'(M1_HREADYOUT), 32'd1);
    chk("e_rst_m0_hreadyout", 32'(M0_HREADYOUT), 32'd1);
    chk("e_rst_s_hsel", 32'(S_HSEL), 32'd0);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      chk("e_post_htrans", 32'(S_HTRANS), 32'd0);
      chk("e_post_m1_hreadyout", 32'(M1_HREADYOUT), 32'd1);
    end

    chk("end_issue_queue", 32'(iq.size()), 32'd0);
    chk("end_m0_queue", 32'(mq0.size()), 32'd0);
    chk("end_m1_queue", 32'(mq1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_bram_arb2.md
AHB_BRAM_ARB2 -- requirements
Module: ahb_bram_arb2

Interface
REQ-001 Parameter ADDRESSWIDTH, default 14, SHALL set the byte-address width of every HADDR port (AW = ADDRESSWIDTH-1).
REQ-002 HCLK  in  1  system bus clock; all state SHALL update on its rising edge.
REQ-003 HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 M<n>_HSEL  in  1  master n slave-select for the shared BRAM, n = 0,1 (likewise for every M<n>_ port).
REQ-005 M<n>_HREADY  in  1  master n bus ready.
REQ-006 M<n>_HTRANS  in  2  master n transfer type.
REQ-007 M<n>_HSIZE  in  2  master n size.
REQ-008 M<n>_HWRITE  in  1  master n write.
REQ-009 M<n>_HADDR  in  ADDRESSWIDTH  master n address.
REQ-010 M<n>_HWDATA  in  32  master n write data.
REQ-011 M<n>_HREADYOUT  out  1  ready to master n.
REQ-012 M<n>_HRESP  out  1  response to master n.
REQ-013 M<n>_HRDATA  out  32  read data to master n.
REQ-014 S_HSEL, S_HTRANS, S_HSIZE, S_HWRITE, S_HADDR, S_HWDATA, S_HREADY  out  1/2/2/1/ADDRESSWIDTH/32/1  shared BRAM port.
REQ-015 S_HREADYOUT  in  1;  S_HRESP  in  1;  S_HRDATA  in  32  shared BRAM responses.

Function
REQ-016 A master request SHALL be live when M<n>_HSEL & M<n>_HREADY & M<n>_HTRANS[1].
REQ-017 Per master, a pending register (addr, size, write, valid) SHALL hold a request that could not be issued in its address cycle.
REQ-018 Slave address slot SHALL be free when the data-phase owner is NONE or S_HREADYOUT=1.
REQ-019 Candidates per master: pending entry if valid, else live request; a master with valid pending SHALL NOT present a new live request.
REQ-020 Slot free, one candidate: it SHALL be issued to the slave that cycle, with the live request driven combinationally (zero added latency).
REQ-021 Slot free, two candidates: round-robin; grant the master not granted last; last-grant SHALL update on every issue.
REQ-022 A live request not issued in its cycle SHALL be captured into that master's pending register at the clock edge.
REQ-023 Issued request SHALL drive S_HSEL=1, S_HTRANS=NONSEQ, controls from the source; no issue SHALL drive S_HSEL=0, S_HTRANS=IDLE, other controls held.
REQ-024 Owner register (NONE/M0/M1) SHALL load the issued master when slot free, else hold; NONE if slot free and nothing issued.
REQ-025 Pending valid SHALL clear on the edge its entry is issued.
REQ-026 S_HWDATA SHALL mux from the owner's M<n>_HWDATA (zero when NONE); S_HREADY = S_HREADYOUT when owner not NONE, else 1.
REQ-027 M<n>_HREADYOUT: S_HREADYOUT if owner=n; 0 if pending valid for n; else 1.
REQ-028 M<n>_HRESP = S_HRESP if owner=n, else OKAY (0); M<n>_HRDATA = S_HRDATA to both masters.
REQ-029 Contended loser with zero-wait slave SHALL see exactly one wait state per lost arbitration; total wait states bounded by one opponent transfer.
REQ-030 Write data for a stalled master SHALL be sampled from its HWDATA in the slave data phase (master holds it while HREADYOUT=0).

Reset
REQ-031 On HRESETn low: pending valid=0 both, owner=NONE, last-grant=M1 (M0 wins first tie); outputs: S_HSEL=0, S_HTRANS=IDLE, M<n>_HREADYOUT=1, M<n>_HRESP=0.
REQ-032 Reset asserted mid-transfer SHALL discard pending and in-flight transfers without a slave issue after release.

Verification
REQ-033 M0 word write 0x11223344 to 0x0010 alone, then read -> no wait states, M0_HRDATA=0x11223344.
REQ-034 M0 and M1 read same cycle after reset -> M0 issued first, M1_HREADYOUT=0 one cycle, M1 issued next cycle.
REQ-035 Back-to-back simultaneous requests x4 -> grants alternate M1,M0,M1,M0 after the first M0.
REQ-036 M1 byte write 0xAB to 0x0003 while M0 in data phase with S_HREADYOUT=0 for 2 cycles -> M1 pending holds, issued when slot frees; byte 3 only written.
REQ-037 HRESETn pulsed while M1 pending -> pending cleared, M1_HREADYOUT=1, S_HTRANS=IDLE next cycle.
REQ-038 S_HRESP=1 during M1 data phase -> M1_HRESP=1, M0_HRESP=0.
